// File: rtl/dmem_miss_ctrl_if.sv
// Bus bundle for the data-cache miss sequencer.
//
// Groups everything except clock and reset:
//   - core request side:   req_valid, req_addr, stall
//   - array lookup inputs: hit, victim_dirty, victim_tag, victim_data
//   - array install port:  arr_we, arr_index, arr_tag, arr_data
//   - backing memory port: mem_req_*, mem_resp_*
//   - perf counters:       hit_cnt, miss_cnt
//
// Modport master is the sequencer itself; slave is the surrounding core, arrays
// and memory.
interface dmem_miss_ctrl_if #(
    parameter int unsigned ADDR_LEN   = 25,
    parameter int unsigned TAG_LEN    = 9,
    parameter int unsigned INDEX_LEN  = 14,
    parameter int unsigned OFFSET_LEN = 2
) ();

    // Core request
    logic                 req_valid;
    logic [ADDR_LEN-1:0]  req_addr;
    logic                 stall;

    // Array lookup result for the indexed line
    logic                 hit;
    logic                 victim_dirty;
    logic [TAG_LEN-1:0]   victim_tag;
    logic [31:0]          victim_data;

    // Array install
    logic                 arr_we;
    logic [INDEX_LEN-1:0] arr_index;
    logic [TAG_LEN-1:0]   arr_tag;
    logic [31:0]          arr_data;

    // Backing memory
    logic                 mem_req_valid;
    logic                 mem_req_we;
    logic [ADDR_LEN-1:0]  mem_req_addr;
    logic [31:0]          mem_req_wdata;
    logic                 mem_req_ready;
    logic                 mem_resp_valid;
    logic [31:0]          mem_resp_data;

    // Performance counters
    logic [31:0]          hit_cnt;
    logic [31:0]          miss_cnt;

    modport master (
        input  req_valid, req_addr, hit, victim_dirty, victim_tag, victim_data,
        input  mem_req_ready, mem_resp_valid, mem_resp_data,
        output stall, arr_we, arr_index, arr_tag, arr_data,
        output mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
        output hit_cnt, miss_cnt
    );

    modport slave (
        output req_valid, req_addr, hit, victim_dirty, victim_tag, victim_data,
        output mem_req_ready, mem_resp_valid, mem_resp_data,
        input  stall, arr_we, arr_index, arr_tag, arr_data,
        input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
        input  hit_cnt, miss_cnt
    );

endinterface

// File: rtl/dmem_miss_ctrl.sv
// Miss sequencer for a direct-mapped, write-back data cache with one 32-bit
// word per line. Address split is {tag, index, offset}.
//
// On a miss the core is stalled, a dirty victim is written back (posted), the
// line is fetched from backing memory and installed clean; the core then
// replays the access, which hits. Hit and miss counters saturate.
//
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset
//   bus  - dmem_miss_ctrl_if.master (core request, array lookup/install,
//          backing-memory request/response, perf counters)
module dmem_miss_ctrl #(
    parameter int unsigned ADDR_LEN   = 25,
    parameter int unsigned TAG_LEN    = 9,
    parameter int unsigned INDEX_LEN  = 14,
    parameter int unsigned OFFSET_LEN = 2
) (
    input  logic              clk,
    input  logic              rst,
    dmem_miss_ctrl_if.master  bus
);

    typedef enum logic [2:0] {
        StIdle,
        StWbReq,
        StFillReq,
        StFillWait,
        StRefill
    } state_e;

    localparam logic [OFFSET_LEN-1:0] OffsetZero = '0;

    // State and latches
    state_e               state_q, state_d;
    logic                 replay_q, replay_d;
    logic [TAG_LEN-1:0]   tag_q, tag_d;
    logic [INDEX_LEN-1:0] index_q, index_d;
    logic [TAG_LEN-1:0]   vtag_q, vtag_d;
    logic [31:0]          vdata_q, vdata_d;
    logic [31:0]          fill_q, fill_d;
    logic [31:0]          hit_cnt_q, hit_cnt_d;
    logic [31:0]          miss_cnt_q, miss_cnt_d;

    // Combinational outputs
    logic                 stall;
    logic                 arr_we;
    logic                 mem_req_valid;
    logic                 mem_req_we;
    logic [ADDR_LEN-1:0]  mem_req_addr;

    // Request address fields
    logic [TAG_LEN-1:0]   req_tag;
    logic [INDEX_LEN-1:0] req_index;
    logic                 unused_offset;

    assign req_tag       = bus.req_addr[ADDR_LEN-1 -: TAG_LEN];
    assign req_index     = bus.req_addr[OFFSET_LEN +: INDEX_LEN];
    // Whole-line accesses only; the byte offset never reaches the memory side.
    assign unused_offset = ^bus.req_addr[OFFSET_LEN-1:0];

    always_comb begin
        state_d       = state_q;
        replay_d      = replay_q;
        tag_d         = tag_q;
        index_d       = index_q;
        vtag_d        = vtag_q;
        vdata_d       = vdata_q;
        fill_d        = fill_q;
        hit_cnt_d     = hit_cnt_q;
        miss_cnt_d    = miss_cnt_q;

        stall         = 1'b1;
        arr_we        = 1'b0;
        mem_req_valid = 1'b0;
        mem_req_we    = 1'b0;
        mem_req_addr  = {tag_q, index_q, OffsetZero};

        unique case (state_q)
            StIdle: begin
                stall    = bus.req_valid & ~bus.hit;
                // The first idle cycle after an install is the replayed access;
                // it was already counted as a miss.
                replay_d = 1'b0;
                if (bus.req_valid && bus.hit && !replay_q && hit_cnt_q != 32'hFFFF_FFFF) begin
                    hit_cnt_d = hit_cnt_q + 32'd1;
                end
                if (bus.req_valid && !bus.hit) begin
                    tag_d   = req_tag;
                    index_d = req_index;
                    if (miss_cnt_q != 32'hFFFF_FFFF) begin
                        miss_cnt_d = miss_cnt_q + 32'd1;
                    end
                    if (bus.victim_dirty) begin
                        vtag_d  = bus.victim_tag;
                        vdata_d = bus.victim_data;
                        state_d = StWbReq;
                    end else begin
                        state_d = StFillReq;
                    end
                end
            end

            StWbReq: begin
                // Posted writeback: acceptance is all we wait for.
                mem_req_valid = 1'b1;
                mem_req_we    = 1'b1;
                mem_req_addr  = {vtag_q, index_q, OffsetZero};
                if (bus.mem_req_ready) begin
                    state_d = StFillReq;
                end
            end

            StFillReq: begin
                mem_req_valid = 1'b1;
                if (bus.mem_req_ready) begin
                    state_d = StFillWait;
                end
            end

            StFillWait: begin
                if (bus.mem_resp_valid) begin
                    fill_d  = bus.mem_resp_data;
                    state_d = StRefill;
                end
            end

            StRefill: begin
                arr_we   = 1'b1;
                replay_d = 1'b1;
                state_d  = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            replay_q   <= 1'b0;
            tag_q      <= '0;
            index_q    <= '0;
            vtag_q     <= '0;
            vdata_q    <= '0;
            fill_q     <= '0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            replay_q   <= replay_d;
            tag_q      <= tag_d;
            index_q    <= index_d;
            vtag_q     <= vtag_d;
            vdata_q    <= vdata_d;
            fill_q     <= fill_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign bus.stall         = stall;
    assign bus.arr_we        = arr_we;
    assign bus.arr_index     = index_q;
    assign bus.arr_tag       = tag_q;
    assign bus.arr_data      = fill_q;
    assign bus.mem_req_valid = mem_req_valid;
    assign bus.mem_req_we    = mem_req_we;
    assign bus.mem_req_addr  = mem_req_addr;
    assign bus.mem_req_wdata = vdata_q;
    assign bus.hit_cnt       = hit_cnt_q;
    assign bus.miss_cnt      = miss_cnt_q;

endmodule
